// File: rtl/handshake_loop_token_gen_pkg.sv
// Shared types and constants for the loop token generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   LOOP_CNT_WIDTH_DEFAULT - default width of trip count / iteration index
//   loop_state_t           - sequencer state (IDLE, ISSUE, DONE), 2-bit encoding
package handshake_loop_pkg;

   localparam int LOOP_CNT_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } loop_state_t;

endpackage : handshake_loop_pkg

// File: rtl/handshake_loop_token_gen_if.sv
// Bundle of the three valid/ready channels around the loop token generator.
// Latency: n/a (wiring only).
// Backpressure: n/a (wiring only).
//
// Optional macro LOOP_TOKEN_GEN_INDEX_EN adds the ctrl_idx signal.
// Modports:
//   master - the token generator: consumes the start token, sources ctrl/done tokens
//   slave  - the surrounding control network: sources start, sinks ctrl/done
interface handshake_loop_token_gen_if #(
   parameter int CNT_WIDTH = handshake_loop_pkg::LOOP_CNT_WIDTH_DEFAULT
);

   // start channel (trip count N rides on the start token)
   logic [CNT_WIDTH-1:0] start_count;
   logic                 start_valid;
   logic                 start_ready;

   // per-iteration control channel
   logic                 ctrl_valid;
   logic                 ctrl_ready;
`ifdef LOOP_TOKEN_GEN_INDEX_EN
   logic [CNT_WIDTH-1:0] ctrl_idx;
`endif

   // loop-complete channel
   logic                 done_valid;
   logic                 done_ready;
   logic [CNT_WIDTH-1:0] done_count;

   modport master (
      input  start_count, start_valid, ctrl_ready, done_ready,
`ifdef LOOP_TOKEN_GEN_INDEX_EN
      output ctrl_idx,
`endif
      output start_ready, ctrl_valid, done_valid, done_count
   );

   modport slave (
      output start_count, start_valid, ctrl_ready, done_ready,
`ifdef LOOP_TOKEN_GEN_INDEX_EN
      input  ctrl_idx,
`endif
      input  start_ready, ctrl_valid, done_valid, done_count
   );

endinterface : handshake_loop_token_gen_if

// File: rtl/handshake_loop_token_gen_loop_iter_counter.sv
// Iteration counter with load, step and terminal-count flag for the loop sequencer.
// Latency: count updates one cycle after load_i/step_i; term_o is decoded from the registered count.
// Backpressure: none; the owner decides when to step.
//
// Optional macro LOOP_TOKEN_GEN_INDEX_EN:
//   defined   - up-counter from 0, term_o when cnt == limit_i-1, count exported on cnt_o
//   undefined - down-counter loaded with load_val_i-1, term_o when cnt == 0
// Ports: clk, rst (sync active-high), load_i, step_i, limit_i/cnt_o or load_val_i, term_o.
module loop_iter_counter
   import handshake_loop_pkg::*;
#(
   parameter int CNT_WIDTH = LOOP_CNT_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic                 step_i,
`ifdef LOOP_TOKEN_GEN_INDEX_EN
   input  logic [CNT_WIDTH-1:0] limit_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
`else
   input  logic [CNT_WIDTH-1:0] load_val_i,
`endif
   output logic                 term_o
);

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
`ifdef LOOP_TOKEN_GEN_INDEX_EN
         cnt_d = '0;
`else
         // N==0 wraps to all-ones here, but the sequencer skips ISSUE for
         // N==0 so this value is never stepped or tested.
         cnt_d = load_val_i - CNT_WIDTH'(1);
`endif
      end else if (step_i) begin
`ifdef LOOP_TOKEN_GEN_INDEX_EN
         cnt_d = cnt_q + CNT_WIDTH'(1);
`else
         cnt_d = cnt_q - CNT_WIDTH'(1);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

`ifdef LOOP_TOKEN_GEN_INDEX_EN
   // limit_i is latched in the same cycle as the load, so it is stable
   // for the whole issue phase. The owner never steps past the terminal
   // count, so the index never reaches limit_i and cannot wrap.
   assign term_o = (cnt_q == (limit_i - CNT_WIDTH'(1)));
   assign cnt_o  = cnt_q;
`else
   assign term_o = (cnt_q == '0);
`endif

endmodule : loop_iter_counter

// File: rtl/handshake_loop_token_gen.sv
// Loop sequencer: one start token with trip count N -> N control tokens -> one done token.
// Latency: first ctrl token 1 cycle after start accept; done 1 cycle after last ctrl handshake (N+2 cycles total, 2 for N==0).
// Backpressure: ctrl and done hold stable until accepted; start_ready stays low until the done token is consumed.
//
// Optional macro LOOP_TOKEN_GEN_INDEX_EN: when defined, bus.ctrl_idx carries the iteration
// index 0..N-1; when undefined the index is not exported and an internal down-counter is used.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset; aborts any loop in flight without a done token
//   bus  - master side of handshake_loop_token_gen_if (start, ctrl, done channels)
// All outputs come straight from registers; there is no combinational path
// from any ready input to any valid output or vice versa.
module handshake_loop_token_gen
   import handshake_loop_pkg::*;
#(
   parameter int CNT_WIDTH = LOOP_CNT_WIDTH_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst,
   handshake_loop_token_gen_if.master  bus
);

   loop_state_t          state_q;
   logic                 start_ready_q;
   logic                 ctrl_valid_q;
   logic                 done_valid_q;
   logic [CNT_WIDTH-1:0] count_q;

   logic                 start_hs;
   logic                 ctrl_hs;
   logic                 last_tok;
`ifdef LOOP_TOKEN_GEN_INDEX_EN
   logic [CNT_WIDTH-1:0] idx;
`endif

   assign start_hs = start_ready_q && bus.start_valid;
   assign ctrl_hs  = ctrl_valid_q && bus.ctrl_ready;

   // Stepping stops at the terminal count so the counter never wraps,
   // even for the maximum trip count.
   loop_iter_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_iter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (start_hs),
      .step_i     (ctrl_hs && !last_tok),
`ifdef LOOP_TOKEN_GEN_INDEX_EN
      .limit_i    (count_q),
      .cnt_o      (idx),
`else
      .load_val_i (bus.start_count),
`endif
      .term_o     (last_tok)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         start_ready_q <= 1'b1;
         ctrl_valid_q  <= 1'b0;
         done_valid_q  <= 1'b0;
         count_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_hs) begin
                  count_q       <= bus.start_count;
                  start_ready_q <= 1'b0;
                  if (bus.start_count == '0) begin
                     state_q      <= DONE;
                     done_valid_q <= 1'b1;
                  end else begin
                     state_q      <= ISSUE;
                     ctrl_valid_q <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (ctrl_hs && last_tok) begin
                  state_q      <= DONE;
                  ctrl_valid_q <= 1'b0;
                  done_valid_q <= 1'b1;
               end
            end
            DONE: begin
               // done_valid is high for the whole state, so done_ready alone
               // is the handshake. start_ready only rises next cycle, which
               // keeps a simultaneous start from being taken here.
               if (bus.done_ready) begin
                  state_q       <= IDLE;
                  done_valid_q  <= 1'b0;
                  start_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q       <= IDLE;
               start_ready_q <= 1'b1;
               ctrl_valid_q  <= 1'b0;
               done_valid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.start_ready = start_ready_q;
   assign bus.ctrl_valid  = ctrl_valid_q;
   assign bus.done_valid  = done_valid_q;
   assign bus.done_count  = count_q;
`ifdef LOOP_TOKEN_GEN_INDEX_EN
   assign bus.ctrl_idx    = idx;
`endif

endmodule : handshake_loop_token_gen

// File: tb/tb_handshake_loop_token_gen.sv
// Self-checking bench for handshake_loop_token_gen (CNT_WIDTH=4).
// Reference: a transaction-level model (busy flag, trip count, tokens issued so far)
// predicts every output each cycle; directed runs pin the model with literal values.
module tb_handshake_loop_token_gen;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   handshake_loop_token_gen_if #(.CNT_WIDTH(W)) bus ();

   handshake_loop_token_gen #(.CNT_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   bit m_seen_rst = 1'b0;
   bit m_busy     = 1'b0;
   int m_n        = 0;
   int m_issued   = 0;
   int cyc        = 0;
   int starts_acc = 0;
   int done_acc   = 0;
   int run_hs     = 0;
   int start_cyc  = 0;
   int done_cyc   = 0;
   int last_dcount = 0;
   int idx_log[$];

   // Compare current outputs with the model, then advance the model with
   // the inputs that will be sampled at the coming rising edge.
   always @(negedge clk) begin
      if (m_seen_rst) begin
         chk("start_ready", 32'(bus.start_ready), 32'(!m_busy));
         chk("ctrl_valid", 32'(bus.ctrl_valid), 32'(m_busy && (m_issued < m_n)));
         chk("done_valid", 32'(bus.done_valid), 32'(m_busy && (m_issued == m_n)));
`ifdef LOOP_TOKEN_GEN_INDEX_EN
         if (m_busy && (m_issued < m_n))
            chk("ctrl_idx", 32'(bus.ctrl_idx), 32'(m_issued));
`endif
         if (m_busy && (m_issued == m_n))
            chk("done_count", 32'(bus.done_count), 32'(m_n));
      end
      cyc++;
      if (rst) begin
         m_seen_rst = 1'b1;
         m_busy     = 1'b0;
         m_n        = 0;
         m_issued   = 0;
      end else if (m_seen_rst) begin
         if (!m_busy) begin
            if (bus.start_valid) begin
               starts_acc++;
               start_cyc = cyc;
               run_hs    = 0;
               idx_log.delete();
               m_busy    = 1'b1;
               m_n       = int'(bus.start_count);
               m_issued  = 0;
            end
         end else if (m_issued < m_n) begin
            if (bus.ctrl_ready) begin
               run_hs++;
               idx_log.push_back(m_issued);
               m_issued++;
            end
         end else if (bus.done_ready) begin
            done_acc++;
            done_cyc    = cyc;
            last_dcount = m_n;
            m_busy      = 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      int k = 0;
      bus.start_count = W'(n);
      bus.start_valid = 1'b1;
      while (k < 100) begin
         @(negedge clk);
         if (bus.start_ready === 1'b1) break;
         k++;
      end
      chk("start_accept_in_time", 32'(k < 100), 32'd1);
      tick();
      bus.start_valid = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int d0 = done_acc;
      int k  = 0;
      while ((done_acc == d0) && (k < limit)) begin
         tick();
         k++;
      end
      chk("done_in_time", 32'(done_acc != d0), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int d0;
      int dbefore;

      rst             = 1'b1;
      bus.start_valid = 1'b0;
      bus.start_count = '0;
      bus.ctrl_ready  = 1'b0;
      bus.done_ready  = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      // reset values
`ifdef LOOP_TOKEN_GEN_INDEX_EN
      chk("reset_ctrl_idx", 32'(bus.ctrl_idx), 32'd0);
`endif
      chk("reset_done_count", 32'(bus.done_count), 32'd0);
      chk("reset_start_ready", 32'(bus.start_ready), 32'd1);
      chk("reset_ctrl_valid", 32'(bus.ctrl_valid), 32'd0);

      // N=4, all readies high
      bus.ctrl_ready = 1'b1;
      bus.done_ready = 1'b1;
      do_start(4);
      wait_done(50);
      chk("n4_handshakes", 32'(run_hs), 32'd4);
      chk("n4_cycles", 32'(done_cyc - start_cyc + 1), 32'd6);
      chk("n4_done_count", 32'(last_dcount), 32'd4);
      chk("n4_idx_count", 32'(idx_log.size()), 32'd4);
      for (int i = 0; i < idx_log.size(); i++) chk("n4_idx_seq", 32'(idx_log[i]), 32'(i));
      chk("n4_start_ready_back", 32'(bus.start_ready), 32'd1);

      // N=0
      do_start(0);
      wait_done(20);
      chk("n0_handshakes", 32'(run_hs), 32'd0);
      chk("n0_cycles", 32'(done_cyc - start_cyc + 1), 32'd2);
      chk("n0_done_count", 32'(last_dcount), 32'd0);

      // N=3 with ctrl_ready 1,0,0,1,1
      do_start(3);
      for (int i = 0; i < 5; i++) begin
         bus.ctrl_ready = pat[i];
`ifdef LOOP_TOKEN_GEN_INDEX_EN
         if (i == 1 || i == 2) chk("stall_idx_hold", 32'(bus.ctrl_idx), 32'd1);
`endif
         if (i == 1 || i == 2) chk("stall_valid_hold", 32'(bus.ctrl_valid), 32'd1);
         tick();
      end
      bus.ctrl_ready = 1'b1;
      wait_done(20);
      chk("stall_handshakes", 32'(run_hs), 32'd3);
      chk("stall_last_idx", 32'(idx_log[idx_log.size()-1]), 32'd2);

      // done held off for 5 cycles while a new start waits
      bus.done_ready = 1'b0;
      do_start(2);
      tick();
      tick();
      chk("hold_done_up", 32'(bus.done_valid), 32'd1);
      bus.start_count = W'(7);
      bus.start_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("hold_start_ready_low", 32'(bus.start_ready), 32'd0);
         chk("hold_done_valid", 32'(bus.done_valid), 32'd1);
         chk("hold_done_count", 32'(bus.done_count), 32'd2);
         tick();
      end
      bus.done_ready = 1'b1;
      do_start(7);
      chk("start_after_done_gap", 32'(start_cyc - done_cyc), 32'd1);
      wait_done(40);
      chk("n7_handshakes", 32'(run_hs), 32'd7);
      chk("n7_done_count", 32'(last_dcount), 32'd7);

      // reset during ISSUE at idx 2 of N=10
      do_start(10);
      tick();
      tick();
`ifdef LOOP_TOKEN_GEN_INDEX_EN
      chk("abort_idx_before", 32'(bus.ctrl_idx), 32'd2);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
      chk("abort_done_valid", 32'(bus.done_valid), 32'd0);
      chk("abort_start_ready", 32'(bus.start_ready), 32'd1);
      d0 = done_acc;
      repeat (5) tick();
      chk("abort_no_done", 32'(done_acc), 32'(d0));
      do_start(1);
      wait_done(20);
      chk("after_abort_handshakes", 32'(run_hs), 32'd1);
      chk("after_abort_done_count", 32'(last_dcount), 32'd1);
      chk("after_abort_done_total", 32'(done_acc), 32'(d0 + 1));

      // maximum trip count for CNT_WIDTH=4
      do_start(15);
      wait_done(60);
      chk("n15_handshakes", 32'(run_hs), 32'd15);
      chk("n15_last_idx", 32'(idx_log[idx_log.size()-1]), 32'd14);
      chk("n15_cycles", 32'(done_cyc - start_cyc + 1), 32'd17);
      chk("n15_done_count", 32'(last_dcount), 32'd15);

      // randomized traffic, including occasional resets
      dbefore = done_acc;
      for (int c = 0; c < 2000; c++) begin
         bus.ctrl_ready  = ($urandom_range(0, 3) != 0);
         bus.done_ready  = ($urandom_range(0, 1) != 0);
         bus.start_valid = ($urandom_range(0, 1) != 0);
         if ($urandom_range(0, 3) == 0) bus.start_count = W'($urandom_range(0, 15));
         else bus.start_count = W'($urandom_range(0, 3));
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst             = 1'b0;
      bus.start_valid = 1'b0;
      bus.ctrl_ready  = 1'b1;
      bus.done_ready  = 1'b1;
      repeat (30) tick();
      chk("random_runs_completed", 32'(done_acc > dbefore), 32'd1);
      chk("random_idle_at_end", 32'(bus.start_ready), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_handshake_loop_token_gen
